// File: rtl/i_format_ctrl_fsm.sv
// ============================================================================
// Module      : i_format_ctrl_fsm
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an I-format
//               datapath with a data-memory handshake timeout and retire count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i_format_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             ext_sign,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic             rf_wsel_mem,
    output logic             dm_re,
    output logic             dm_we,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_SLTI = 6'h0A;
    localparam logic [5:0] c_OP_ANDI = 6'h0C;
    localparam logic [5:0] c_OP_ORI  = 6'h0D;
    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2B;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b100;

    localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [31:0]      r_ir;
    logic [7:0]       r_tcnt;
    logic [CNT_W-1:0] r_retired;

    logic [5:0] w_opc;
    logic       w_legal;
    logic       w_is_br;
    logic       w_is_beq;
    logic       w_is_lw;
    logic       w_is_sw;
    logic [2:0] w_alu_op;
    logic       w_src_imm;
    logic       w_ext_sign;
    logic       w_timeout;
    logic       w_retire;
    logic       w_unused_ir;

    assign w_opc       = r_ir[31:26];
    assign w_timeout   = (r_tcnt == c_TIMEOUT);
    assign w_unused_ir = ^{r_ir[25:21], r_ir[15:0]};

    always_comb begin
        w_legal    = 1'b1;
        w_is_br    = 1'b0;
        w_is_beq   = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_alu_op   = c_ALU_ADD;
        w_src_imm  = 1'b1;
        w_ext_sign = 1'b1;
        case (w_opc)
            c_OP_ADDI: w_alu_op = c_ALU_ADD;
            c_OP_SLTI: w_alu_op = c_ALU_SLT;
            c_OP_ANDI: begin w_alu_op = c_ALU_AND; w_ext_sign = 1'b0; end
            c_OP_ORI:  begin w_alu_op = c_ALU_OR;  w_ext_sign = 1'b0; end
            c_OP_LW:   w_is_lw = 1'b1;
            c_OP_SW:   w_is_sw = 1'b1;
            c_OP_BEQ, c_OP_BNE: begin
                w_is_br   = 1'b1;
                w_is_beq  = (w_opc == c_OP_BEQ);
                w_alu_op  = c_ALU_SUB;
                w_src_imm = 1'b0;
            end
            default:   w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_ERR;
            S_EXEC: begin
                if (w_is_br)                w_next = S_IDLE;
                else if (w_is_lw || w_is_sw) w_next = S_MEM;
                else                        w_next = S_WB;
            end
            S_MEM: begin
                if (w_timeout)      w_next = S_IDLE;
                else if (mem_ready) w_next = w_is_lw ? S_WB : S_IDLE;
            end
            S_WB:     w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ir_load       = 1'b0;
        alu_op        = 3'b000;
        alu_src_imm   = 1'b0;
        ext_sign      = 1'b0;
        rf_we         = 1'b0;
        rf_wsel_mem   = 1'b0;
        dm_re         = 1'b0;
        dm_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        done          = 1'b0;
        illegal       = 1'b0;
        mem_err       = 1'b0;
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            alu_op      = w_alu_op;
            alu_src_imm = w_src_imm;
            ext_sign    = w_ext_sign;
        end
        case (r_state)
            S_FETCH: ir_load = 1'b1;
            S_EXEC: begin
                if (w_is_br) begin
                    pc_we         = 1'b1;
                    done          = 1'b1;
                    pc_sel_branch = w_is_beq ? zero : !zero;
                end
            end
            S_MEM: begin
                // Timeout wins over a late ack so the abort cycle is deterministic
                if (w_timeout) begin
                    mem_err = 1'b1;
                    done    = 1'b1;
                    pc_we   = 1'b1;
                end else begin
                    dm_re = w_is_lw;
                    dm_we = w_is_sw;
                    if (mem_ready && w_is_sw) begin
                        pc_we = 1'b1;
                        done  = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we       = 1'b1;
                rf_wsel_mem = w_is_lw;
                pc_we       = 1'b1;
                done        = 1'b1;
            end
            S_ERR: begin
                illegal = 1'b1;
                done    = 1'b1;
                pc_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_retire = done && !illegal && !mem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir      <= 32'd0;
            r_tcnt    <= 8'd0;
            r_retired <= '0;
        end else begin
            if (r_state == S_FETCH) r_ir <= instr;
            if (r_state == S_EXEC)
                r_tcnt <= 8'd0;
            else if (r_state == S_MEM && !mem_ready && !w_timeout)
                r_tcnt <= r_tcnt + 8'd1;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign rf_waddr = r_ir[20:16];
    assign busy     = (r_state != S_IDLE);
    assign retired  = r_retired;

endmodule

`default_nettype wire
